// File: rtl/uart_rx_oversample.sv
// UART receiver on a 16x oversample tick: sync, 3-tap majority filter,
// 7/8-bit frames with optional parity, held byte plus status flags.
`timescale 1ns/1ps
module uart_rx_oversample #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [2:0] flt_q;
  logic rxs, rxf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      flt_q  <= 3'b111;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      if (baud_clock) flt_q <= {flt_q[1:0], rxs};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];
  assign rxf = (flt_q[0] & flt_q[1]) |
               (flt_q[0] & flt_q[2]) |
               (flt_q[1] & flt_q[2]);

  state_t state_q, state_d;
  logic [3:0] scnt_q, scnt_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic m8_q, m8_d;
  logic mpar_q, mpar_d;
  logic modd_q, modd_d;
  logic perr_q, perr_d;
  logic brk_q, brk_d;
  logic [7:0] data_d;
  logic ready_d, pe_d, fe_d, ovf_d;
  logic load;
  logic [7:0] data_w;
  logic [3:0] last;

  assign data_w = m8_q ? shreg_q : {1'b0, shreg_q[7:1]};
  assign last   = m8_q ? 4'd7 : 4'd6;

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    m8_d    = m8_q;
    mpar_d  = mpar_q;
    modd_d  = modd_q;
    perr_d  = perr_q;
    brk_d   = brk_q;
    load    = 1'b0;
    if (baud_clock) begin
      unique case (state_q)
        IDLE: begin
          if (!rxf) begin
            state_d = START;
            scnt_d  = 4'd0;
            m8_d    = bit8;
            mpar_d  = parity_en;
            modd_d  = odd_n_even;
          end else begin
            brk_d = 1'b0;
          end
        end
        START: begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd7) begin
            scnt_d = 4'd0;
            // a line still low after a framing error is a break
            if (!rxf && !brk_q) begin
              state_d = DATA;
              bcnt_d  = 4'd0;
              perr_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            shreg_d = {rxf, shreg_q[7:1]};
            bcnt_d  = bcnt_q + 4'd1;
            if (bcnt_q == last)
              state_d = mpar_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            perr_d  = (^data_w) ^ rxf ^ modd_q;
            state_d = STOP;
          end
        end
        STOP: begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            load    = 1'b1;
            brk_d   = ~rxf;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    data_d  = rx_data;
    ready_d = rx_ready;
    pe_d    = parity_err;
    fe_d    = framing_err;
    ovf_d   = overflow;
    if (load) begin
      data_d  = data_w;
      ready_d = 1'b1;
      pe_d    = mpar_q & perr_q;
      fe_d    = ~rxf;
      ovf_d   = rx_ready & ~read_rx_byte;
    end else if (read_rx_byte) begin
      ready_d = 1'b0;
      pe_d    = 1'b0;
      fe_d    = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      scnt_q      <= 4'd0;
      bcnt_q      <= 4'd0;
      shreg_q     <= 8'd0;
      m8_q        <= 1'b0;
      mpar_q      <= 1'b0;
      modd_q      <= 1'b0;
      perr_q      <= 1'b0;
      brk_q       <= 1'b0;
      rx_data     <= 8'd0;
      rx_ready    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      bcnt_q      <= bcnt_d;
      shreg_q     <= shreg_d;
      m8_q        <= m8_d;
      mpar_q      <= mpar_d;
      modd_q      <= modd_d;
      perr_q      <= perr_d;
      brk_q       <= brk_d;
      rx_data     <= data_d;
      rx_ready    <= ready_d;
      parity_err  <= pe_d;
      framing_err <= fe_d;
      overflow    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: serial frames from a
// bit-level model, expected bytes queued, monitor reads and compares.
`timescale 1ns/1ps
module tb_uart_rx_oversample;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic baud_clock;
  logic rx = 1'b1;
  logic bit8 = 1'b1;
  logic parity_en = 1'b0;
  logic odd_n_even = 1'b0;
  logic read_auto = 1'b0;
  logic read_man = 1'b0;
  logic read_rx_byte;
  logic [7:0] rx_data;
  logic rx_ready, parity_err, framing_err, overflow;
  logic [1:0] bdiv = 2'd0;

  uart_rx_oversample #(.SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .baud_clock(baud_clock),
    .rx(rx),
    .bit8(bit8),
    .parity_en(parity_en),
    .odd_n_even(odd_n_even),
    .read_rx_byte(read_rx_byte),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .parity_err(parity_err),
    .framing_err(framing_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) bdiv <= bdiv + 2'd1;
  assign baud_clock = (bdiv == 2'd3);
  assign read_rx_byte = read_auto | read_man;

  typedef struct packed {
    logic [7:0] d;
    logic pe;
    logic fe;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int nbytes = 0;
  bit auto_read = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic align();
    do @(negedge clk); while (bdiv != 2'd0);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit m8,
                            input bit pen, input bit odd,
                            input bit bad_par, input bit stop,
                            input int bp);
    logic [7:0] dm;
    logic pbit;
    exp_t e;
    int nb;
    nb = m8 ? 8 : 7;
    dm = m8 ? d : {1'b0, d[6:0]};
    pbit = (odd ? ~(^dm) : ^dm) ^ bad_par;
    e.d  = dm;
    e.pe = pen && (((^dm) ^ pbit) != odd);
    e.fe = !stop;
    if (auto_read) q.push_back(e);
    bit8 = m8;
    parity_en = pen;
    odd_n_even = odd;
    rx = 1'b0;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rx = dm[i];
      repeat (bp) @(negedge clk);
    end
    if (pen) begin
      rx = pbit;
      repeat (bp) @(negedge clk);
    end
    rx = stop;
    repeat (bp) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (q.size() != 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk(nm, q.size(), 0);
  endtask

  task automatic pulse_read();
    read_man = 1'b1;
    @(negedge clk);
    read_man = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (auto_read && reset_n && rx_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_byte", {24'd0, rx_data}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("rx_data", rx_data, e.d);
          chk("parity_err", parity_err, e.pe);
          chk("framing_err", framing_err, e.fe);
          chk("overflow_auto", overflow, 0);
        end
        nbytes++;
        read_auto = 1'b1;
        @(negedge clk);
        read_auto = 1'b0;
        chk("ready_clear", rx_ready, 0);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, k, gap;
    logic [7:0] d;
    bit m8, pen, odd, bad, stp;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {rx_data, rx_ready, parity_err, framing_err, overflow}, 0);
    reset_n = 1'b1;
    idle(128);

    align();
    send_frame(8'hA5, 1, 0, 0, 0, 1, 64);
    drain("drain_8n1");

    send_frame(8'h41, 0, 1, 0, 0, 1, 64);
    send_frame(8'h41, 0, 1, 0, 1, 1, 64);
    send_frame(8'hFF, 1, 1, 1, 0, 1, 64);
    send_frame(8'hFF, 1, 1, 1, 1, 1, 64);
    drain("drain_parity");

    send_frame(8'h3C, 1, 0, 0, 0, 0, 64);
    idle(128);
    drain("drain_framing");

    n0 = nbytes;
    q.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
    rx = 1'b0;
    repeat (30 * 64) @(negedge clk);
    idle(192);
    drain("drain_break");
    chk("break_count", nbytes - n0, 1);

    n0 = nbytes;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(300);
    rx = 1'b0;
    repeat (24) @(negedge clk);
    idle(300);
    chk("glitch_nobyte", nbytes - n0, 0);
    chk("glitch_ready", rx_ready, 0);

    for (int i = 0; i < 16; i++) begin
      d   = 8'($urandom);
      m8  = 1'($urandom);
      pen = 1'($urandom);
      odd = 1'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 5) != 0);
      send_frame(d, m8, pen, odd, bad, stp, $urandom_range(63, 65));
      gap = stp ? $urandom_range(0, 80) : 160;
      idle(gap);
    end
    drain("drain_random");

    auto_read = 1'b0;
    k = 0;
    align();
    send_frame(8'h11, 1, 0, 0, 0, 1, 64);
    fork
      send_frame(8'h22, 1, 0, 0, 0, 1, 64);
      begin
        for (int i = 1; i <= 1500; i++) begin
          @(negedge clk);
          if (rx_data == 8'h22) begin
            k = i;
            break;
          end
        end
      end
    join
    idle(64);
    chk("load_seen", (k != 0), 1);
    chk("ovf_data", rx_data, 8'h22);
    chk("ovf_flag", overflow, 1);
    chk("ovf_ready", rx_ready, 1);
    chk("ovf_ferr", framing_err, 0);
    pulse_read();
    chk("read_clr_ready", rx_ready, 0);
    chk("read_clr_ovf", overflow, 0);
    idle(128);

    align();
    send_frame(8'h11, 1, 0, 0, 0, 1, 64);
    fork
      send_frame(8'h22, 1, 0, 0, 0, 1, 64);
      begin
        if (k > 1) begin
          repeat (k - 1) @(negedge clk);
          pulse_read();
        end
      end
    join
    idle(64);
    chk("rdload_data", rx_data, 8'h22);
    chk("rdload_ovf", overflow, 0);
    chk("rdload_ready", rx_ready, 1);
    pulse_read();
    idle(128);

    send_frame(8'h77, 1, 0, 0, 0, 1, 64);
    idle(64);
    chk("pre_reset_ready", rx_ready, 1);
    rx = 1'b0;
    repeat (64) @(negedge clk);
    rx = 1'b1;
    repeat (64) @(negedge clk);
    rx = 1'b0;
    repeat (64) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midframe_reset",
        {rx_data, rx_ready, parity_err, framing_err, overflow}, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(192);

    auto_read = 1'b1;
    fork
      send_frame(8'h5A, 1, 0, 0, 0, 1, 64);
      begin
        repeat (64 * 4) @(negedge clk);
        bit8 = 1'b0;
      end
    join
    idle(64);
    drain("drain_mode_latch");

    chk("final_queue", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
